// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential floating-point divider (restoring, one quotient bit
// per cycle). Same operand format as the combinational fp multiplier:
// {sign, EXP_W biased exponent, FRAC_W fraction}, hidden leading 1,
// truncated fraction, raw biased exponent exposed on exp_sum.
// Optional feature macro: FPDIV_SPECIAL_EN (zero/Inf/NaN classification with
// a short path straight to DONE and a registered div_by_zero flag).
module fp_div_seq #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int BIAS   = 127
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [EXP_W+FRAC_W:0]     flp_a,
   input  logic [EXP_W+FRAC_W:0]     flp_b,
   output logic                      busy,
   output logic                      done,
   output logic [EXP_W+FRAC_W:0]     quot,
   output logic [EXP_W+1:0]          exp_sum,
   output logic                      div_by_zero
);

   localparam int W  = 1 + EXP_W + FRAC_W;   // operand / result width
   localparam int MW = FRAC_W + 1;           // mantissa with hidden 1
   localparam int RW = FRAC_W + 3;           // partial remainder width
   localparam int QW = FRAC_W + 2;           // quotient bits produced
   localparam int CW = $clog2(QW + 1);       // iteration counter width
   localparam logic [CW-1:0]      LAST_CNT = CW'(QW - 1);
   localparam logic [EXP_W+1:0]   BIAS_V   = (EXP_W + 2)'(BIAS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_r;
   logic                busy_r;
   logic                done_r;
   logic [W-1:0]        quot_r;
   logic [EXP_W+1:0]    exp_sum_r;
   logic [CW-1:0]       cnt_r;
   logic                sign_r;
   logic [EXP_W-1:0]    ea_r;
   logic [EXP_W-1:0]    eb_r;
   logic [MW-1:0]       b_man_r;
   logic [RW-1:0]       rem_r;
   logic [QW-1:0]       q_r;

   logic                rem_ge_s;
   logic [RW-1:0]       rem_sub_s;
   logic [RW-1:0]       rem_next_s;
   logic [EXP_W+1:0]    exp_hi_s;
   logic [EXP_W+1:0]    exp_sel_s;
   logic [FRAC_W-1:0]   frac_sel_s;

   // One restoring-division step and the normalisation selection.
   always_comb begin
      rem_ge_s   = (rem_r >= {2'b00, b_man_r});
      rem_sub_s  = rem_r - {2'b00, b_man_r};
      if (rem_ge_s) begin
         rem_next_s = {rem_sub_s[RW-2:0], 1'b0};
      end else begin
         rem_next_s = {rem_r[RW-2:0], 1'b0};
      end
      // Unsigned arithmetic modulo 2^(EXP_W+2) yields the signed result bits.
      exp_hi_s = {2'b00, ea_r} + BIAS_V - {2'b00, eb_r};
      if (q_r[QW-1]) begin
         exp_sel_s  = exp_hi_s;
         frac_sel_s = q_r[FRAC_W:1];
      end else begin
         exp_sel_s  = exp_hi_s - {{(EXP_W+1){1'b0}}, 1'b1};
         frac_sel_s = q_r[FRAC_W-1:0];
      end
   end

`ifdef FPDIV_SPECIAL_EN
   logic          dbz_r;
   logic          special_s;
   logic [W-1:0]  spec_quot_s;
   logic          spec_dbz_s;
   logic          za_s, zb_s, ia_s, ib_s, na_s, nb_s, sgn_s;

   // Operand classification: exponent 0 is zero, all-ones is Inf/NaN.
   always_comb begin
      sgn_s = flp_a[W-1] ^ flp_b[W-1];
      za_s  = (flp_a[W-2:FRAC_W] == {EXP_W{1'b0}});
      zb_s  = (flp_b[W-2:FRAC_W] == {EXP_W{1'b0}});
      ia_s  = (flp_a[W-2:FRAC_W] == {EXP_W{1'b1}});
      ib_s  = (flp_b[W-2:FRAC_W] == {EXP_W{1'b1}});
      na_s  = ia_s && (flp_a[FRAC_W-1:0] != {FRAC_W{1'b0}});
      nb_s  = ib_s && (flp_b[FRAC_W-1:0] != {FRAC_W{1'b0}});
      special_s   = za_s || zb_s || ia_s || ib_s;
      spec_dbz_s  = 1'b0;
      spec_quot_s = {W{1'b0}};
      if (na_s || nb_s || (za_s && zb_s) || (ia_s && ib_s)) begin
         // Invalid operation: canonical quiet NaN.
         spec_quot_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
         spec_dbz_s  = zb_s;
      end else if (zb_s) begin
         spec_quot_s = {sgn_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         spec_dbz_s  = 1'b1;
      end else if (za_s || ib_s) begin
         spec_quot_s = {sgn_s, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
      end else if (ia_s) begin
         spec_quot_s = {sgn_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else begin
         spec_quot_s = {W{1'b0}};
      end
   end

   assign div_by_zero = dbz_r;
`else
   assign div_by_zero = 1'b0;
`endif

   // Control FSM, iterative datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         quot_r    <= {W{1'b0}};
         exp_sum_r <= {(EXP_W+2){1'b0}};
         cnt_r     <= {CW{1'b0}};
         sign_r    <= 1'b0;
         ea_r      <= {EXP_W{1'b0}};
         eb_r      <= {EXP_W{1'b0}};
         b_man_r   <= {MW{1'b0}};
         rem_r     <= {RW{1'b0}};
         q_r       <= {QW{1'b0}};
`ifdef FPDIV_SPECIAL_EN
         dbz_r     <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  sign_r  <= flp_a[W-1] ^ flp_b[W-1];
                  ea_r    <= flp_a[W-2:FRAC_W];
                  eb_r    <= flp_b[W-2:FRAC_W];
                  b_man_r <= {1'b1, flp_b[FRAC_W-1:0]};
                  rem_r   <= {2'b01, flp_a[FRAC_W-1:0]};
                  q_r     <= {QW{1'b0}};
                  cnt_r   <= {CW{1'b0}};
`ifdef FPDIV_SPECIAL_EN
                  dbz_r   <= 1'b0;
                  if (special_s) begin
                     quot_r  <= spec_quot_s;
                     dbz_r   <= spec_dbz_s;
                     state_r <= S_DONE;
                  end else begin
                     busy_r  <= 1'b1;
                     state_r <= S_DIV;
                  end
`else
                  busy_r  <= 1'b1;
                  state_r <= S_DIV;
`endif
               end
            end
            S_DIV: begin
               rem_r <= rem_next_s;
               q_r   <= {q_r[QW-2:0], rem_ge_s};
               if (cnt_r == LAST_CNT) begin
                  state_r <= S_NORM;
               end else begin
                  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            S_NORM: begin
               quot_r    <= {sign_r, exp_sel_s[EXP_W-1:0], frac_sel_s};
               exp_sum_r <= exp_sel_s;
               busy_r    <= 1'b0;
               state_r   <= S_DONE;
            end
            S_DONE: begin
               done_r  <= 1'b1;
               state_r <= S_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign quot    = quot_r;
   assign exp_sum = exp_sum_r;

endmodule
